// File: rtl/axil_frame_seq.sv
// Frame sequencer: arbitrates two header requesters and splits each frame into
// single-beat AXI-Lite commands. Optional macro AXIL_FRAME_SEQ_ERR_ABORT_EN ends a frame on the first error beat.
module axil_frame_seq #(
    parameter int ADDR_STRIDE = 4,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [43:0]      req0_head,
    input  logic [43:0]      req1_head,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_rw,
    output logic [31:0]      cmd_addr,
    input  logic             rsp_valid,
    input  logic             rsp_err,
    input  logic             tx_fifo_empty,
    input  logic             rx_fifo_full,
    output logic             frame_done,
    output logic             frame_err,
    output logic             frame_src,
    output logic [LEN_W-1:0] frame_beats,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic [31:0]        addr_q, addr_d;
    logic               rw_q, rw_d;
    logic               src_q, src_d;
    logic               err_q, err_d;
    logic               last_grant_q, last_grant_d;
    logic               hold_q, hold_d;

    logic               any_req;
    logic               gnt_src;
    logic [43:0]        gnt_head;
    logic               gate_open;
    logic               cmd_fire;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // once cmd_valid is raised it is held (hold_q) with address/rw stable until cmd_ready.
    assign any_req   = req0_valid | req1_valid;
    assign gnt_src   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign gnt_head  = gnt_src ? req1_head : req0_head;
    assign gate_open = rw_q ? !tx_fifo_empty : !rx_fifo_full;
    assign cmd_valid = (state_q == ISSUE) && (gate_open || hold_q);
    assign cmd_fire  = cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        beats_d      = beats_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        src_d        = src_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;
        hold_d       = hold_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    req0_ready   = !gnt_src;
                    req1_ready   = gnt_src;
                    last_grant_d = gnt_src;
                    src_d        = gnt_src;
                    len_d        = LEN_W'(gnt_head[43:28]);
                    addr_d       = {8'd0, gnt_head[27:4]};
                    rw_d         = gnt_head[0];
                    beats_d      = '0;
                    err_d        = 1'b0;
                    hold_d       = 1'b0;
                    state_d      = (gnt_head[43:28] == 16'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_fire) begin
                    hold_d  = 1'b0;
                    state_d = WAIT_RSP;
                end else if (cmd_valid) begin
                    hold_d = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid) begin
                    beats_d = beats_q + 1'b1;
                    err_d   = err_q | rsp_err;
                    if (beats_d == len_q) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 32'(ADDR_STRIDE);
                        state_d = ISSUE;
                    end
`ifdef AXIL_FRAME_SEQ_ERR_ABORT_EN
                    if (rsp_err) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            beats_q      <= '0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            src_q        <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
            hold_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            beats_q      <= beats_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            src_q        <= src_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
        end
    end

    // Completion fields are only driven during the one-cycle DONE pulse.
    assign frame_done  = (state_q == DONE);
    assign frame_err   = frame_done & err_q;
    assign frame_src   = frame_done & src_q;
    assign frame_beats = frame_done ? beats_q : '0;
    assign busy        = (state_q != IDLE);
    assign cmd_addr    = addr_q;
    assign cmd_rw      = rw_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/axil_frame_seq.md
AXIL_FRAME_SEQ -- requirements
Module: axil_frame_seq

Interface
REQ-001 SHALL have parameter ADDR_STRIDE, default 4: byte increment of cmd_addr between beats.
REQ-002 SHALL have parameter LEN_W, default 16: width of frame length field and beat counter.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1: requester has a frame header.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1: header accepted this cycle.
REQ-007 SHALL have ports req0_head / req1_head, input, 44: {len[43:28], addr[27:4], opcode[3:0]}; rw = opcode[0], 1 = write.
REQ-008 SHALL have ports cmd_valid output 1, cmd_ready input 1, cmd_rw output 1, cmd_addr output 32: single-beat command to the AXI-Lite master engine.
REQ-009 SHALL have ports rsp_valid input 1, rsp_err input 1: beat completion from the engine; rsp_err = engine timeout/error.
REQ-010 SHALL have ports tx_fifo_empty input 1, rx_fifo_full input 1: beat gating.
REQ-011 SHALL have ports frame_done output 1, frame_err output 1, frame_src output 1, frame_beats output LEN_W: completion report; busy output 1.

Function
REQ-012 States SHALL be IDLE, ISSUE, WAIT_RSP, DONE; busy = (state != IDLE).
REQ-013 IDLE: if any req_valid, grant one; assert its req_ready combinationally that cycle; latch len, addr (zero-extended to 32), rw, src; clear beat count; go to ISSUE.
REQ-014 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; one valid -> grant it; last_grant updates on every grant.
REQ-015 Header with len = 0 SHALL go IDLE -> DONE with no command, frame_beats = 0, frame_err = 0.
REQ-016 ISSUE: cmd_valid SHALL rise only when gate is open (write: !tx_fifo_empty; read: !rx_fifo_full); once high it SHALL stay high with cmd_addr/cmd_rw stable until cmd_ready.
REQ-017 cmd_valid & cmd_ready SHALL move to WAIT_RSP next cycle; cmd_valid low in WAIT_RSP.
REQ-018 WAIT_RSP: on rsp_valid, beat count += 1, error flag |= rsp_err; if new count == len go to DONE, else cmd_addr += ADDR_STRIDE (mod 2^32, wraps silently) and go to ISSUE.
REQ-019 rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-020 DONE: frame_done high exactly one cycle with frame_err, frame_src, frame_beats valid that cycle; next state IDLE.
REQ-021 req_ready SHALL be low in every state except IDLE; no new header is accepted in the DONE cycle.
REQ-022 Minimum per-beat latency: ISSUE to cmd handshake 0 cycles if gate open and cmd_ready high; 1 cycle to WAIT_RSP; rsp_valid closes the beat.

Reset
REQ-023 On reset: state IDLE, cmd_valid 0, req0_ready/req1_ready 0, frame_done 0, frame_err 0, frame_src 0, frame_beats 0, cmd_addr 0, cmd_rw 0, busy 0, last_grant = 1 (req0 wins first tie).
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse; outstanding engine responses after reset are ignored.

Configuration
REQ-025 Macro AXIL_FRAME_SEQ_ERR_ABORT_EN defined: rsp_err in WAIT_RSP SHALL go straight to DONE with frame_err = 1 and frame_beats = beats completed including the failed one.
REQ-026 Macro AXIL_FRAME_SEQ_ERR_ABORT_EN undefined: rsp_err SHALL be recorded sticky in frame_err and the frame continues to len beats.

Verification
REQ-027 req0 head len=3, addr=0x000100, write; cmd_ready, rsp_valid always 1 -> cmd_addr 0x100, 0x104, 0x108; one frame_done, frame_beats=3, frame_err=0, frame_src=0.
REQ-028 req0 and req1 valid simultaneously after reset, len=1 each -> req0 served first, then req1; frame_src 0 then 1.
REQ-029 Read frame len=2 with rx_fifo_full=1 for 10 cycles -> cmd_valid stays 0 for those cycles, then 2 beats complete.
REQ-030 addr=0xFFFFFC, len=2, ADDR_STRIDE=4 -> second cmd_addr = 0x01000000 (no wrap at 24 bits; 32-bit wrap only at 0xFFFFFFFC).
REQ-031 len=4, rsp_err=1 on beat 2 -> with ERR_ABORT_EN: frame_done after 2 beats, frame_err=1, frame_beats=2; without: 4 beats, frame_err=1.
REQ-032 reset asserted while in WAIT_RSP of a len=5 frame -> next cycle all outputs at reset values, no frame_done.
